spi_slave: RTL and testbench

- SPI responder (slave) side of the team's SPI link; counterpart to the existing SPI master block.
- Oversamples external sclk/cs_n/mosi in the system clock domain and assembles received words of configurable width.
- Serialises transmit words onto miso through a one-entry transmit holding buffer with a valid/ready handshake.
- Supports all four CPOL/CPHA modes, MSB/LSB-first ordering, back-to-back words within one chip-select frame, and underrun and frame-abort reporting.

---
 rtl/spi_pkg.sv | 20 ++
 rtl/spi_sync_edge.sv | 32 +++
 rtl/spi_slave.sv | 186 ++++++++++++++++++
 tb/tb_spi_slave.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI responder: mode encodings, FSM states and
// the word-width clamp applied when configuration is captured.
package spi_pkg;

    localparam logic [1:0] MODE0 = 2'b00;
    localparam logic [1:0] MODE1 = 2'b01;
    localparam logic [1:0] MODE2 = 2'b10;
    localparam logic [1:0] MODE3 = 2'b11;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    function automatic int unsigned effective_width(input int unsigned data_width,
                                                    input int unsigned max_width);
        return (data_width == 0 || data_width > max_width) ? max_width : data_width;
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-stage synchroniser for one asynchronous pin, with a registered copy
// of the synchronised level used to produce single-cycle rise/fall strobes.
module spi_sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {SYNC_STAGES{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = level & ~prev_q;
    assign fall  = ~level & prev_q;

endmodule

// File: rtl/spi_slave.sv
// SPI responder: oversamples sclk/cs_n/mosi in the clk domain, assembles rx
// words and serialises tx words from a one-entry holding buffer.
module spi_slave
    import spi_pkg::*;
#(
    parameter int MAX_DATA_WIDTH = 32,
    parameter int SYNC_STAGES    = 2
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [$clog2(MAX_DATA_WIDTH):0] data_width,
    input  logic                            lsb_first,
    input  logic                            cpol,
    input  logic                            cpha,
    input  logic [MAX_DATA_WIDTH-1:0]       tx_data,
    input  logic                            tx_valid,
    output logic                            tx_ready,
    output logic [MAX_DATA_WIDTH-1:0]       rx_data,
    output logic                            rx_valid,
    output logic                            busy,
    output logic                            underrun,
    output logic                            frame_err,
    input  logic                            sclk,
    input  logic                            cs_n,
    input  logic                            mosi,
    output logic                            miso,
    output logic                            miso_oe
);

    localparam int WW = $clog2(MAX_DATA_WIDTH) + 1;
    localparam int IW = (MAX_DATA_WIDTH > 1) ? $clog2(MAX_DATA_WIDTH) : 1;
    localparam logic [WW-1:0] ONE = WW'(1);

    logic sclk_rise, sclk_fall, sclk_lvl_unused;
    logic cs_rise, cs_fall, cs_lvl_unused;
    logic mosi_s, mosi_rise_unused, mosi_fall_unused;

    // cs_n resets to 0 so a frame already in progress at reset release never
    // produces a fall; the block waits for cs_n high then low again.
    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst_n(rst_n), .din(sclk),
        .level(sclk_lvl_unused), .rise(sclk_rise), .fall(sclk_fall));
    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_cs (
        .clk(clk), .rst_n(rst_n), .din(cs_n),
        .level(cs_lvl_unused), .rise(cs_rise), .fall(cs_fall));
    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .rst_n(rst_n), .din(mosi),
        .level(mosi_s), .rise(mosi_rise_unused), .fall(mosi_fall_unused));

    state_t                    state_q, state_d;
    logic [WW-1:0]             cfg_width_q, bit_cnt_q;
    logic                      cfg_lsb_q;
    logic [1:0]                cfg_mode_q;
    logic [MAX_DATA_WIDTH-1:0] rx_shift_q, tx_shift_q, buf_q, rx_data_q;
    logic                      buf_full_q, rx_valid_q, underrun_q, frame_err_q;
    logic                      miso_q, empty_word_q;

    logic                      lead, trail, sample, drive, complete, abort, word_start, load;
    logic                      ws_lsb;
    logic [WW-1:0]             ws_width, new_width;
    logic [IW-1:0]             cur_idx, first_idx;
    logic [MAX_DATA_WIDTH-1:0] rx_word;

    function automatic logic [IW-1:0] bit_idx(input logic [WW-1:0] n, input logic lsb,
                                              input logic [WW-1:0] w);
        return lsb ? IW'(n) : IW'(w - ONE - n);
    endfunction

    assign new_width = WW'(effective_width(32'(data_width), MAX_DATA_WIDTH));
    assign load      = tx_valid & ~buf_full_q;

    always_comb begin
        state_d    = state_q;
        word_start = 1'b0;
        sample     = 1'b0;
        drive      = 1'b0;
        complete   = 1'b0;
        abort      = 1'b0;
        lead       = 1'b0;
        trail      = 1'b0;
        ws_lsb     = cfg_lsb_q;
        ws_width   = cfg_width_q;
        case (cfg_mode_q)
            MODE0, MODE1: begin lead = sclk_rise; trail = sclk_fall; end
            default:      begin lead = sclk_fall; trail = sclk_rise; end
        endcase
        case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    state_d    = ACTIVE;
                    word_start = 1'b1;
                    ws_lsb     = lsb_first;
                    ws_width   = new_width;
                end
            end
            ACTIVE: begin
                sample   = (cfg_mode_q == MODE0 || cfg_mode_q == MODE2) ? lead : trail;
                drive    = (cfg_mode_q == MODE0 || cfg_mode_q == MODE2) ? trail : lead;
                complete = sample && (bit_cnt_q == cfg_width_q - ONE);
                if (cs_rise) begin
                    state_d = IDLE;
                    abort   = !complete && (bit_cnt_q != '0);
                end else begin
                    word_start = complete;
                end
            end
        endcase
    end

    always_comb begin
        cur_idx          = bit_idx(bit_cnt_q, cfg_lsb_q, cfg_width_q);
        first_idx        = bit_idx('0, ws_lsb, ws_width);
        rx_word          = rx_shift_q;
        rx_word[cur_idx] = mosi_s;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cfg_width_q  <= WW'(MAX_DATA_WIDTH);
            cfg_lsb_q    <= 1'b0;
            cfg_mode_q   <= MODE0;
            bit_cnt_q    <= '0;
            rx_shift_q   <= '0;
            tx_shift_q   <= '0;
            buf_q        <= '0;
            buf_full_q   <= 1'b0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            underrun_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            miso_q       <= 1'b0;
            empty_word_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rx_valid_q  <= complete;
            frame_err_q <= abort;
            underrun_q  <= 1'b0;
            if (load) buf_q <= tx_data;
            buf_full_q <= load | (buf_full_q & ~word_start);
            if (sample) begin
                if (complete) begin
                    rx_data_q <= rx_word;
                end else begin
                    rx_shift_q <= rx_word;
                    bit_cnt_q  <= bit_cnt_q + ONE;
                end
            end
            if (drive) miso_q <= tx_shift_q[cur_idx];
            // Underrun is reported once the master actually clocks the empty
            // word, so the spare word start after a frame's last word is silent.
            if (lead && empty_word_q && state_d == ACTIVE) begin
                underrun_q   <= 1'b1;
                empty_word_q <= 1'b0;
            end
            if (word_start) begin
                if (state_q == IDLE) begin
                    cfg_width_q <= ws_width;
                    cfg_lsb_q   <= lsb_first;
                    cfg_mode_q  <= {cpol, cpha};
                end
                tx_shift_q   <= buf_full_q ? buf_q : '0;
                miso_q       <= buf_full_q & buf_q[first_idx];
                empty_word_q <= ~buf_full_q;
                bit_cnt_q    <= '0;
                rx_shift_q   <= '0;
            end
            if (state_d == IDLE) begin
                miso_q       <= 1'b0;
                bit_cnt_q    <= '0;
                rx_shift_q   <= '0;
                empty_word_q <= 1'b0;
            end
        end
    end

    assign tx_ready  = ~buf_full_q;
    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign busy      = (state_q == ACTIVE);
    assign miso_oe   = (state_q == ACTIVE);
    assign miso      = miso_q;
    assign underrun  = underrun_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: behavioural SPI master plus a word-level reference
// (masked words, consumed-buffer order, underrun count) checked per frame.
module tb_spi_slave;

    localparam int HALF = 6;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [5:0]  data_width;
    logic        lsb_first, cpol, cpha;
    logic [31:0] tx_data;
    logic        tx_valid, tx_ready;
    logic [31:0] rx_data;
    logic        rx_valid, busy, underrun, frame_err;
    logic        sclk, cs_n, mosi, miso, miso_oe;

    spi_slave #(.MAX_DATA_WIDTH(32), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .data_width(data_width), .lsb_first(lsb_first),
        .cpol(cpol), .cpha(cpha), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy),
        .underrun(underrun), .frame_err(frame_err), .sclk(sclk), .cs_n(cs_n),
        .mosi(mosi), .miso(miso), .miso_oe(miso_oe));

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    int          n_under  = 0;
    int          n_ferr   = 0;
    logic [31:0] rx_q[$];
    logic [31:0] mosi_w[4];
    logic [31:0] feed_w[4];
    logic [31:0] cap_w[4];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rx_valid) rx_q.push_back(rx_data);
        if (underrun) n_under++;
        if (frame_err) n_ferr++;
    end

    task automatic half_period();
        repeat (HALF) @(negedge clk);
    endtask

    task automatic feed(input int k);
        for (int i = 0; i < k; i++) begin
            int t = 0;
            while (!tx_ready && t < 3000) begin
                @(negedge clk);
                t++;
            end
            if (!tx_ready) begin
                check("feed_timeout", tx_ready, 1);
                break;
            end
            tx_data  = feed_w[i];
            tx_valid = 1'b1;
            @(negedge clk);
            tx_valid = 1'b0;
        end
    endtask

    task automatic drive_frame(input bit pol, input bit pha, input bit lsb, input int eff,
                               input int nw, input int cut_bits, input bit cut_rst);
        int          done_bits = 0;
        bit          stop = 0;
        logic [31:0] cap;
        sclk = pol;
        repeat (4) half_period();
        cs_n = 1'b0;
        half_period();
        check("busy_oe_active", {busy, miso_oe}, 2'b11);
        for (int w = 0; w < nw && !stop; w++) begin
            cap = '0;
            for (int b = 0; b < eff; b++) begin
                int idx = lsb ? b : eff - 1 - b;
                if (!pha) begin
                    mosi = mosi_w[w][idx];
                    half_period(); sclk = ~pol; cap[idx] = miso;
                    half_period(); sclk = pol;
                end else begin
                    half_period(); sclk = ~pol; mosi = mosi_w[w][idx];
                    half_period(); sclk = pol; cap[idx] = miso;
                end
                done_bits++;
                if (cut_bits > 0 && done_bits == cut_bits) begin
                    if (cut_rst) begin
                        rst_n = 1'b0;
                        @(negedge clk);
                        check("rst_mid_flags",
                              {tx_ready, rx_valid, busy, underrun, frame_err, miso, miso_oe},
                              7'b1000000);
                        check("rst_mid_rx", rx_data, 0);
                        @(negedge clk);
                        rst_n = 1'b1;
                        for (int k = 0; k < 5; k++) begin
                            half_period(); sclk = ~pol;
                            half_period(); sclk = pol;
                        end
                        check("rst_mid_ignored", {busy, miso_oe}, 2'b00);
                    end
                    stop = 1;
                    break;
                end
            end
            cap_w[w] = cap;
        end
        half_period();
        cs_n = 1'b1;
        repeat (4) half_period();
    endtask

    task automatic run_frame(input logic [1:0] mode, input bit lsb, input logic [5:0] dw,
                             input int nw, input int nfeed, input int cut_bits,
                             input bit cut_rst);
        int          eff;
        logic [63:0] m64;
        logic [31:0] mask;
        eff  = (dw == 0 || dw > 32) ? 32 : int'(dw);
        m64  = (64'd1 << eff) - 64'd1;
        mask = m64[31:0];
        rx_q.delete();
        n_under    = 0;
        n_ferr     = 0;
        data_width = dw;
        lsb_first  = lsb;
        cpol       = mode[1];
        cpha       = mode[0];
        fork
            feed(nfeed);
            drive_frame(mode[1], mode[0], lsb, eff, nw, cut_bits, cut_rst);
        join
        if (cut_bits > 0) begin
            check("cut_rx_cnt", rx_q.size(), 0);
            check("cut_frame_err", n_ferr, cut_rst ? 0 : 1);
            check("cut_underrun", n_under, (cut_rst || nfeed > 0) ? 0 : 1);
        end else begin
            check("rx_cnt", rx_q.size(), nw);
            for (int w = 0; w < nw; w++) begin
                if (w < rx_q.size()) check("rx_data", rx_q[w], mosi_w[w] & mask);
                check("miso_word", cap_w[w], (w < nfeed) ? (feed_w[w] & mask) : 32'h0);
            end
            check("underrun_cnt", n_under, nw - nfeed);
            check("frame_err_cnt", n_ferr, 0);
        end
        check("idle_outputs", {busy, miso_oe, miso, tx_ready}, 4'b0001);
    endtask

    initial begin
        rst_n = 1'b0; cs_n = 1'b1; sclk = 1'b0; mosi = 1'b0;
        tx_valid = 1'b0; tx_data = '0; data_width = 6'd8;
        lsb_first = 1'b0; cpol = 1'b0; cpha = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_flags", {tx_ready, rx_valid, busy, underrun, frame_err, miso, miso_oe},
              7'b1000000);
        check("rst_rx", rx_data, 0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        mosi_w[0] = 32'hA5; feed_w[0] = 32'h3C;
        run_frame(2'b00, 1'b0, 6'd8, 1, 1, 0, 1'b0);

        mosi_w[0] = 32'h1234; feed_w[0] = 32'hBEEF;
        run_frame(2'b11, 1'b1, 6'd16, 1, 1, 0, 1'b0);

        mosi_w[0] = 32'hF0; mosi_w[1] = 32'h0F; feed_w[0] = 32'h11; feed_w[1] = 32'h22;
        run_frame(2'b01, 1'b0, 6'd8, 2, 2, 0, 1'b0);

        mosi_w[0] = 32'hC7;
        run_frame(2'b00, 1'b0, 6'd8, 1, 0, 0, 1'b0);

        mosi_w[0] = 32'h96;
        run_frame(2'b00, 1'b0, 6'd8, 1, 0, 5, 1'b0);
        mosi_w[0] = 32'h69; feed_w[0] = 32'hC3;
        run_frame(2'b00, 1'b0, 6'd8, 1, 1, 0, 1'b0);

        mosi_w[0] = 32'hFF; feed_w[0] = 32'h81;
        run_frame(2'b00, 1'b0, 6'd8, 1, 1, 3, 1'b1);
        mosi_w[0] = 32'h5A; feed_w[0] = 32'h77;
        run_frame(2'b00, 1'b0, 6'd8, 1, 1, 0, 1'b0);

        for (int r = 0; r < 16; r++) begin
            int nw = $urandom_range(1, 3);
            int nf = $urandom_range(0, nw);
            for (int i = 0; i < 4; i++) begin
                mosi_w[i] = $urandom;
                feed_w[i] = $urandom;
            end
            run_frame(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                      6'($urandom_range(0, 40)), nw, nf, 0, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
